// File: rtl/sparc_windowed_regfile.sv
// SPARC-style windowed integer register file: 8 globals plus 2**CWP_W overlapping
// 16-register windows, two combinational read ports, one write port, SAVE/RESTORE with WIM traps.
module sparc_windowed_regfile #(
    parameter int WIDTH = 32,
    parameter int CWP_W = 3
) (
    input  logic                  Clk,
    input  logic                  Clr,
    input  logic [4:0]            RA,
    input  logic [4:0]            RB,
    output logic [WIDTH-1:0]      DA,
    output logic [WIDTH-1:0]      DB,
    input  logic [4:0]            RW,
    input  logic [WIDTH-1:0]      DW,
    input  logic                  loadE,
    input  logic                  Save,
    input  logic                  Restore,
    input  logic                  CwpLoadE,
    input  logic [CWP_W-1:0]      CwpIn,
    input  logic [2**CWP_W-1:0]   WIM,
    output logic [CWP_W-1:0]      CWP,
    output logic                  WinOvf,
    output logic                  WinUnf
);

    localparam int unsigned NREGS = 8 + 16 * (2**CWP_W);
    localparam int          PA_W  = CWP_W + 5;

    logic [WIDTH-1:0] regs [NREGS];
    logic [CWP_W-1:0] cwp_dec;
    logic [CWP_W-1:0] cwp_inc;

    // Outs of window w sit at 16w+8, so r8..r23 map to 16c+r; ins borrow the next window's outs.
    function automatic logic [PA_W-1:0] phys(input logic [4:0] r, input logic [CWP_W-1:0] c);
        logic [CWP_W-1:0] w;
        w = (r >= 5'd24) ? c + 1'b1 : c;
        if (r < 5'd8)
            phys = {{CWP_W{1'b0}}, r};
        else if (r < 5'd24)
            phys = {1'b0, w, 4'b0000} + {{CWP_W{1'b0}}, r};
        else
            phys = {1'b0, w, 4'b0000} + {{CWP_W{1'b0}}, r} - PA_W'(16);
    endfunction

    always_comb begin
        DA = '0;
        DB = '0;
        if (RA != 5'd0) DA = regs[phys(RA, CWP)];
        if (RB != 5'd0) DB = regs[phys(RB, CWP)];
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[PA_W'(i)] <= '0;
        end else if (!loadE && RW != 5'd0) begin
            regs[phys(RW, CWP)] <= DW;
        end
    end

    always_comb begin
        cwp_dec = CWP - 1'b1;
        cwp_inc = CWP + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            CWP    <= '0;
            WinOvf <= 1'b0;
            WinUnf <= 1'b0;
        end else begin
            WinOvf <= 1'b0;
            WinUnf <= 1'b0;
            if (!CwpLoadE) begin
                CWP <= CwpIn;
            end else if (Save && Restore) begin
                CWP <= CWP;
            end else if (Save) begin
                if (WIM[cwp_dec]) WinOvf <= 1'b1;
                else              CWP    <= cwp_dec;
            end else if (Restore) begin
                if (WIM[cwp_inc]) WinUnf <= 1'b1;
                else              CWP    <= cwp_inc;
            end
        end
    end

endmodule

// File: tb/tb_sparc_windowed_regfile.sv
// Self-checking bench for sparc_windowed_regfile: directed scenarios plus randomized
// traffic compared against an architectural window model.
module tb_sparc_windowed_regfile;

    localparam int WIDTH = 32;
    localparam int CWP_W = 3;
    localparam int NW    = 8;

    logic             Clk = 1'b0;
    logic             Clr = 1'b0;
    logic [4:0]       RA = '0, RB = '0, RW = '0;
    logic [WIDTH-1:0] DA, DB, DW = '0;
    logic             loadE = 1'b1, Save = 1'b0, Restore = 1'b0, CwpLoadE = 1'b1;
    logic [CWP_W-1:0] CwpIn = '0;
    logic [NW-1:0]    WIM = '0;
    logic [CWP_W-1:0] CWP;
    logic             WinOvf, WinUnf;

    always #5 Clk = ~Clk;

    sparc_windowed_regfile #(.WIDTH(WIDTH), .CWP_W(CWP_W)) dut (
        .Clk(Clk), .Clr(Clr), .RA(RA), .RB(RB), .DA(DA), .DB(DB),
        .RW(RW), .DW(DW), .loadE(loadE), .Save(Save), .Restore(Restore),
        .CwpLoadE(CwpLoadE), .CwpIn(CwpIn), .WIM(WIM),
        .CWP(CWP), .WinOvf(WinOvf), .WinUnf(WinUnf)
    );

    // Architectural model: globals, per-window outs and locals
    logic [31:0] m_glob [8];
    logic [31:0] m_outs [NW][8];
    logic [31:0] m_locs [NW][8];
    int          m_cwp;
    logic        m_ovf, m_unf;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input int r);
        if (r == 0)       return 32'h0;
        else if (r < 8)   return m_glob[r];
        else if (r < 16)  return m_outs[m_cwp][r-8];
        else if (r < 24)  return m_locs[m_cwp][r-16];
        else              return m_outs[(m_cwp+1)%NW][r-24];
    endfunction

    task automatic mclear();
        for (int i = 0; i < 8; i++) m_glob[i] = '0;
        for (int w = 0; w < NW; w++)
            for (int i = 0; i < 8; i++) begin
                m_outs[w][i] = '0;
                m_locs[w][i] = '0;
            end
        m_cwp = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic tick();
        logic s_clr, s_le, s_sv, s_rs, s_cl;
        logic [4:0] s_rw;
        logic [31:0] s_dw;
        logic [CWP_W-1:0] s_ci;
        logic [NW-1:0] s_wim;
        int n;
        s_clr = Clr; s_le = loadE; s_sv = Save; s_rs = Restore; s_cl = CwpLoadE;
        s_rw = RW; s_dw = DW; s_ci = CwpIn; s_wim = WIM;
        @(posedge Clk);
        #1;
        if (s_clr) mclear();
        else begin
            if (!s_le && s_rw != 0) begin
                if (s_rw < 8)       m_glob[s_rw] = s_dw;
                else if (s_rw < 16) m_outs[m_cwp][s_rw-8] = s_dw;
                else if (s_rw < 24) m_locs[m_cwp][s_rw-16] = s_dw;
                else                m_outs[(m_cwp+1)%NW][s_rw-24] = s_dw;
            end
            m_ovf = 0; m_unf = 0;
            if (!s_cl) m_cwp = int'(s_ci);
            else if (s_sv && !s_rs) begin
                n = (m_cwp + NW - 1) % NW;
                if (s_wim[n]) m_ovf = 1; else m_cwp = n;
            end else if (s_rs && !s_sv) begin
                n = (m_cwp + 1) % NW;
                if (s_wim[n]) m_unf = 1; else m_cwp = n;
            end
        end
        chk("cwp", 32'(CWP), 32'(m_cwp));
        chk("ovf", 32'(WinOvf), 32'(m_ovf));
        chk("unf", 32'(WinUnf), 32'(m_unf));
        chk("da", DA, mread(int'(RA)));
        chk("db", DB, mread(int'(RB)));
    endtask

    task automatic expect_rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        RA = a;
        #1;
        chk(tag, DA, exp);
    endtask

    task automatic idle();
        loadE = 1'b1; Save = 1'b0; Restore = 1'b0; CwpLoadE = 1'b1; Clr = 1'b0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        RW = r; DW = v; loadE = 1'b0;
        tick();
        loadE = 1'b1;
    endtask

    task automatic load_cwp(input logic [CWP_W-1:0] c);
        CwpIn = c; CwpLoadE = 1'b0;
        tick();
        CwpLoadE = 1'b1;
    endtask

    initial begin
        mclear();
        Clr = 1'b1; tick(); Clr = 1'b0;
        expect_rd(5'd5, 32'h0, "rst_r5");
        RB = 5'd31; #1; chk("rst_db", DB, 32'h0);

        // Reset clears register contents
        wr(5'd5, 32'hDEADBEEF);
        expect_rd(5'd5, 32'hDEADBEEF, "r5_written");
        Clr = 1'b1; tick(); Clr = 1'b0;
        expect_rd(5'd5, 32'h0, "r5_after_clr");
        chk("cwp_after_clr", 32'(CWP), 32'h0);

        wr(5'd0, 32'h12345678);
        expect_rd(5'd0, 32'h0, "r0_const");

        // Window overlap
        WIM = '0;
        wr(5'd8, 32'hA5A5A5A5);
        Save = 1'b1; tick(); Save = 1'b0;
        chk("save_wrap", 32'(CWP), 32'd7);
        expect_rd(5'd24, 32'hA5A5A5A5, "ins_overlap");
        Restore = 1'b1; tick(); Restore = 1'b0;
        chk("restore_wrap", 32'(CWP), 32'd0);
        expect_rd(5'd8, 32'hA5A5A5A5, "outs_back");

        // Globals shared, locals private
        wr(5'd3, 32'h11);
        wr(5'd17, 32'h22);
        Save = 1'b1; tick(); Save = 1'b0;
        expect_rd(5'd3, 32'h11, "global_shared");
        expect_rd(5'd17, 32'h0, "local_private");
        Restore = 1'b1; tick(); Restore = 1'b0;
        expect_rd(5'd17, 32'h22, "local_restored");

        // Overflow at CWP=0
        WIM = 8'h80;
        Save = 1'b1; tick(); Save = 1'b0;
        chk("ovf_cwp", 32'(CWP), 32'd0);
        chk("ovf_pulse", 32'(WinOvf), 32'd1);
        tick();
        chk("ovf_clear", 32'(WinOvf), 32'd0);

        // Underflow at CWP=7
        WIM = '0;
        load_cwp(3'd7);
        WIM = 8'h01;
        Restore = 1'b1; tick(); Restore = 1'b0;
        chk("unf_cwp", 32'(CWP), 32'd7);
        chk("unf_pulse", 32'(WinUnf), 32'd1);
        tick();
        chk("unf_clear", 32'(WinUnf), 32'd0);

        // Back-to-back trapped saves hold the flag high
        WIM = 8'h40;
        Save = 1'b1; tick();
        chk("ovf_b2b_1", 32'(WinOvf), 32'd1);
        tick();
        chk("ovf_b2b_2", 32'(WinOvf), 32'd1);
        Save = 1'b0; tick();
        chk("ovf_b2b_end", 32'(WinOvf), 32'd0);

        // Simultaneous save and restore
        WIM = '0;
        Save = 1'b1; Restore = 1'b1; tick(); idle();
        chk("sr_cwp", 32'(CWP), 32'd7);
        chk("sr_notrap", 32'({WinOvf, WinUnf}), 32'd0);

        // Direct load beats a trapping save
        WIM = 8'hFF; Save = 1'b1; CwpIn = 3'd5; CwpLoadE = 1'b0;
        tick(); idle();
        chk("ld_cwp", 32'(CWP), 32'd5);
        chk("ld_notrap", 32'(WinOvf), 32'd0);

        // Write with save targets the pre-edge window
        WIM = '0;
        load_cwp(3'd2);
        RW = 5'd16; DW = 32'h77; loadE = 1'b0; Save = 1'b1;
        tick(); idle();
        chk("ws_cwp", 32'(CWP), 32'd1);
        expect_rd(5'd16, 32'h0, "ws_new_local");
        Restore = 1'b1; tick(); Restore = 1'b0;
        expect_rd(5'd16, 32'h77, "ws_old_local");

        // No write bypass
        RA = 5'd9; RW = 5'd9; DW = 32'h55; loadE = 1'b0;
        #1;
        chk("nobyp_old", DA, 32'h0);
        tick(); loadE = 1'b1;
        chk("nobyp_new", DA, 32'h55);

        // Reset during a trapping save leaves no trap
        load_cwp(3'd0);
        WIM = 8'h80; Save = 1'b1; Clr = 1'b1;
        tick(); idle();
        chk("clr_notrap", 32'(WinOvf), 32'd0);
        expect_rd(5'd9, 32'h0, "clr_regs");

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            RA = 5'($urandom_range(0, 31));
            RB = 5'($urandom_range(0, 31));
            RW = 5'($urandom_range(0, 31));
            DW = $urandom;
            loadE = $urandom_range(0, 1) == 0;
            Save = $urandom_range(0, 3) == 0;
            Restore = $urandom_range(0, 3) == 0;
            CwpLoadE = $urandom_range(0, 15) != 0;
            CwpIn = 3'($urandom_range(0, 7));
            WIM = 8'($urandom & $urandom & $urandom);
            Clr = $urandom_range(0, 199) == 0;
            tick();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sparc_windowed_regfile.md
Name: sparc_windowed_regfile

Overview:
- Parametrised successor of the single 32-bit load-enable register: a SPARC-style windowed integer register file built from the same load-enable storage element.
- Provides 8 globals plus NWINDOWS overlapping 16-register windows, two asynchronous read ports and one synchronous write port.
- Implements SAVE/RESTORE window rotation with WIM-based overflow/underflow detection.
- Sits between decode (read addresses) and writeback (write port) in the integer pipeline.

Parameters:
- WIDTH, 32, data width of every register.
- CWP_W, 3, width of the current window pointer; NWINDOWS = 2**CWP_W (legal CWP_W 1..5).

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Clr  input  1  synchronous reset, active-high.
- RA  input  5  read address, port A (architectural r0..r31).
- RB  input  5  read address, port B.
- DA  output  WIDTH  read data, port A.
- DB  output  WIDTH  read data, port B.
- RW  input  5  write address.
- DW  input  WIDTH  write data.
- loadE  input  1  write enable, active-low.
- Save  input  1  SAVE request, active-high.
- Restore  input  1  RESTORE request, active-high.
- CwpLoadE  input  1  direct CWP load (WRPSR path), active-low.
- CwpIn  input  CWP_W  value for direct CWP load.
- WIM  input  NWINDOWS  window invalid mask; bit w set = window w invalid.
- CWP  output  CWP_W  current window pointer.
- WinOvf  output  1  window overflow trap, one-cycle pulse.
- WinUnf  output  1  window underflow trap, one-cycle pulse.

Behaviour:
- Storage: 8 + 16*NWINDOWS physical registers of WIDTH bits.
  - Physical 0..7 hold globals (p0 unused).
  - Window w outs at 8+16w..8+16w+7; locals at 16+16w..16+16w+7.
- Architectural mapping at current CWP=c:
  - r0: reads constant 0.
  - r1..r7: globals.
  - r8..r15: outs of c.
  - r16..r23: locals of c.
  - r24..r31: ins of c = outs of window (c+1) mod NWINDOWS.
- Reads are combinational from RA/RB and current CWP. There is no write bypass: a same-cycle write is visible on DA/DB only after the rising edge.
- Writes: on rising edge with loadE=0 and RW!=0, DW goes to the location RW maps to under the CWP before that edge. Writes with RW=0 are discarded. Simultaneous Save/Restore does not affect the write target.
- CWP update per rising edge (Clr=0), in priority order:
  1. CwpLoadE=0: CWP <= CwpIn; Save/Restore ignored; no trap.
  2. Save=1 and Restore=1: no change; no trap.
  3. Save=1: n = (CWP-1) mod NWINDOWS. If WIM[n]=1, CWP holds and WinOvf=1 for the next cycle; otherwise CWP <= n.
  4. Restore=1: n = (CWP+1) mod NWINDOWS. If WIM[n]=1, CWP holds and WinUnf=1 for the next cycle; otherwise CWP <= n.
  5. Otherwise CWP holds.
- Wrap-around is modular: CWP=0 with Save goes to NWINDOWS-1; CWP=NWINDOWS-1 with Restore goes to 0.
- WinOvf and WinUnf are registered, high exactly one cycle per trapped request, and clear the next cycle unless re-triggered. Back-to-back trapped Saves give a continuous high.
- Reset (Clr=1 at rising edge): CWP=0, WinOvf=0, WinUnf=0, all physical registers cleared to 0. Reset overrides any concurrent write, Save, Restore or CwpLoadE. Reset mid-sequence discards pending state with no residual trap.
- Outputs after reset: DA=DB=0 for any address.

Test Plan:
- Reset/r0:
  - Write 0xDEADBEEF to r5, assert Clr one cycle: DA(r5)=0, CWP=0.
  - Write 0x12345678 to r0: DA(r0)=0.
- Window overlap:
  - At CWP=0, write 0xA5A5A5A5 to r8, then Save with WIM=0: CWP=7 (NWINDOWS=8) and DA(r24)=0xA5A5A5A5.
  - Restore: CWP=0 and DA(r8)=0xA5A5A5A5.
- Globals/locals:
  - Write r3=0x11 and r17=0x22 at CWP=0, then Save: DA(r3)=0x11 and DA(r17)=0.
  - Restore: DA(r17)=0x22.
- Overflow/underflow:
  - CWP=0, WIM=0x80, Save: CWP stays 0 and WinOvf=1 for exactly one cycle.
  - CWP=7, WIM=0x01, Restore: CWP stays 7 and WinUnf pulses once.
- Simultaneous events:
  - Save=Restore=1: CWP unchanged, no trap.
  - CwpLoadE=0 with CwpIn=5 plus Save and WIM=0xFF: CWP=5, no trap.
  - Write r16=0x77 with Save at CWP=2: value lands in window 2 locals, readable after Restore.
- No bypass:
  - Write r9=0x55 while RA=9: DA shows the old value that cycle and 0x55 the next.
